// File: rtl/uart_prog_loader_if.sv
// rtl/uart_prog_loader_if.sv - memory write bus driven by the UART program loader
interface uart_prog_loader_if;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;

    modport master (
        output upg_wen_o,
        output upg_adr_o,
        output upg_dat_o,
        output upg_done_o
    );

    modport slave (
        input upg_wen_o,
        input upg_adr_o,
        input upg_dat_o,
        input upg_done_o
    );
endinterface

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - 8N1 receiver that assembles words into ROM/RAM writes and replies with an ACK byte
module uart_prog_loader #(
    parameter int         CLK_DIV   = 87,
    parameter int         ROM_WORDS = 16384,
    parameter int         RAM_WORDS = 16384,
    parameter int         TIMEOUT   = 1000000,
    parameter logic [7:0] ACK_BYTE  = 8'h4F
) (
    input  logic                       upg_clk_i,
    input  logic                       upg_rst_i,
    input  logic                       upg_rx_i,
    output logic                       upg_clk_o,
    output logic                       upg_tx_o,
    uart_prog_loader_if.master         bus
);
    localparam int CNT_W  = $clog2(CLK_DIV + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int N_W    = 16;

    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [IDLE_W-1:0] IDLE_M1 = IDLE_W'(TIMEOUT - 1);
    localparam logic [N_W-1:0]    ROM_N   = N_W'(ROM_WORDS);
    localparam logic [N_W-1:0]    TOTAL_N = N_W'(ROM_WORDS + RAM_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_WAIT_FIRST, LD_LOAD, LD_ACK, LD_DONE} ld_state_t;

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;

    ld_state_t       ld_state_q, ld_state_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [23:0]     word_q, word_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic            wen_q, wen_d;
    logic [14:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic            done_q, done_d;
    logic            tx_q, tx_d;
    logic [8:0]      tx_shift_q, tx_shift_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;

    logic            adr_sel;
    logic [13:0]     adr_idx;

    assign upg_clk_o      = upg_clk_i;
    assign upg_tx_o       = tx_q;
    assign bus.upg_wen_o  = wen_q;
    assign bus.upg_adr_o  = adr_q;
    assign bus.upg_dat_o  = dat_q;
    assign bus.upg_done_o = done_q;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                // A start bit that is no longer low at mid-bit is a glitch.
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == FULL_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (rx_cnt_q == FULL_M1) begin
                    rx_state_d   = RX_IDLE;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign adr_sel = (n_q >= ROM_N);
    assign adr_idx = adr_sel ? 14'(n_q - ROM_N) : 14'(n_q);

    always_comb begin
        ld_state_d = ld_state_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        n_d        = n_q;
        idle_d     = idle_q;
        wen_d      = 1'b0;
        adr_d      = adr_q;
        dat_d      = dat_q;
        done_d     = done_q;
        tx_d       = tx_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_cnt_d   = tx_cnt_q;
        case (ld_state_q)
            LD_WAIT_FIRST, LD_LOAD: begin
                if (ld_state_q == LD_LOAD) idle_d = idle_q + IDLE_W'(1);
                if (byte_valid_q) begin
                    ld_state_d = LD_LOAD;
                    idle_d     = '0;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = rx_shift_q;
                        2'd1: word_d[15:8]  = rx_shift_q;
                        2'd2: word_d[23:16] = rx_shift_q;
                        default: begin
                            dat_d = {rx_shift_q, word_q};
                            adr_d = {adr_sel, adr_idx};
                            wen_d = 1'b1;
                        end
                    endcase
                end else if (frame_err_q) begin
                    byte_idx_d = '0;
                end
                // Completion by count wins over the idle timeout; a byte landing now defers the timeout.
                if (wen_q || (ld_state_q == LD_LOAD && !byte_valid_q && idle_q == IDLE_M1)) begin
                    if (wen_q) n_d = n_q + N_W'(1);
                    if (!wen_q || (n_q + N_W'(1) == TOTAL_N)) begin
                        ld_state_d = LD_ACK;
                        done_d     = 1'b1;
                        tx_d       = 1'b0;
                        tx_shift_d = {1'b1, ACK_BYTE};
                        tx_bit_d   = '0;
                        tx_cnt_d   = '0;
                    end
                end
            end
            LD_ACK: begin
                if (tx_cnt_q == FULL_M1) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        ld_state_d = LD_DONE;
                        tx_d       = 1'b1;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[8:1]};
                        tx_bit_d   = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ld_state_q   <= LD_WAIT_FIRST;
            byte_idx_q   <= '0;
            word_q       <= '0;
            n_q          <= '0;
            idle_q       <= '0;
            wen_q        <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            done_q       <= 1'b0;
            tx_q         <= 1'b1;
            tx_shift_q   <= '1;
            tx_bit_q     <= '0;
            tx_cnt_q     <= '0;
        end else begin
            rx_meta_q    <= upg_rx_i;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            ld_state_q   <= ld_state_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            n_q          <= n_d;
            idle_q       <= idle_d;
            wen_q        <= wen_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            done_q       <= done_d;
            tx_q         <= tx_d;
            tx_shift_q   <= tx_shift_d;
            tx_bit_q     <= tx_bit_d;
            tx_cnt_q     <= tx_cnt_d;
        end
    end
endmodule
